sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_beat_timer.sv | 43 ++++
 rtl/sram_burst_ctrl.sv | 89 ++++++++
 tb/tb_sram_burst_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst controller: FSM states and
// bit positions inside the active-low sramCtrl bundle.
package sram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int CTRL_WE_N = 4;
  localparam int CTRL_UB_N = 3;
  localparam int CTRL_LB_N = 2;
  localparam int CTRL_CE_N = 1;
  localparam int CTRL_OE_N = 0;

  localparam int HW_W    = 16;
  localparam int SRAM_AW = 18;
endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state counter and beat index for one SRAM burst; clears whenever
// the controller is not in its access state.
module sram_beat_timer #(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 3,
  parameter int BEAT_W      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [BEAT_W-1:0] beat_o,
  output logic              beat_last,
  output logic              access_last
);
  logic [2:0]        count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign beat_last   = run && (count_q == 3'(WAIT_CYCLES - 1));
  assign access_last = beat_last && (beat_q == BEAT_W'(BEATS - 1));
  assign beat_o      = beat_q;

  always_comb begin
    count_d = count_q + 3'd1;
    beat_d  = beat_q;
    if (!run || access_last) begin
      count_d = '0;
      beat_d  = '0;
    end else if (beat_last) begin
      count_d = '0;
      beat_d  = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      beat_q  <= '0;
    end else begin
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: rtl/sram_burst_ctrl.sv
// Bridges a WORD_W-wide pipeline load/store port onto a 16-bit async SRAM,
// splitting each word into little-endian halfword beats of WAIT_CYCLES each.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memReadEn,
  input  logic              memWriteEn,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData,
  output logic              ready,
  inout  wire  [15:0]       sramData,
  output logic [17:0]       sramAddress,
  output logic [4:0]        sramCtrl
);
  localparam int BEATS  = WORD_W / HW_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHIFT  = $clog2(WORD_W / 8);

  state_e              state_q;
  logic [SRAM_AW-1:0]  base_q;
  logic [WORD_W-1:0]   wdata_q, rdata_q;
  logic                is_wr_q;

  logic [BEAT_W-1:0]   beat;
  logic                beat_last, access_last;
  logic                req, in_wr_beat;
  logic [31:0]         word_idx;

  assign req        = memReadEn | memWriteEn;
  assign word_idx   = (address - 32'(BASE_ADDR)) >> SHIFT;
  assign in_wr_beat = (state_q == ST_ACCESS) && is_wr_q;

  sram_beat_timer #(
    .BEATS      (BEATS),
    .WAIT_CYCLES(WAIT_CYCLES),
    .BEAT_W     (BEAT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (state_q == ST_ACCESS),
    .beat_o     (beat),
    .beat_last  (beat_last),
    .access_last(access_last)
  );

  // Reset overrides ready so a request held through reset cannot stall the pipe.
  assign ready = !rst || (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

  assign sramData    = in_wr_beat ? wdata_q[beat*HW_W +: HW_W] : 16'hzzzz;
  assign sramAddress = base_q + SRAM_AW'(beat);
  assign readData    = rdata_q;

  always_comb begin
    sramCtrl            = '0;
    sramCtrl[CTRL_WE_N] = !(in_wr_beat && !beat_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req) begin
          state_q <= ST_ACCESS;
          base_q  <= SRAM_AW'(word_idx * 32'(BEATS));
          wdata_q <= writeData;
          is_wr_q <= memWriteEn;
        end
        ST_ACCESS: begin
          if (!is_wr_q && beat_last) rdata_q[beat*HW_W +: HW_W] <= sramData;
          if (access_last) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomized bench for sram_burst_ctrl: transaction-level memory model plus
// per-cycle protocol observation, with a second 64-bit instance.
module tb_sram_burst_ctrl;
  localparam int WAIT = 3;
  localparam logic [15:0] PROBE = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // 32-bit instance
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        rdy;
  wire  [15:0] bus;
  logic [17:0] saddr;
  logic [4:0]  sctrl;
  logic        tb_rd = 1'b0, probe_en = 1'b0;
  logic        drv_en;
  logic [15:0] drv_val;
  logic [15:0] sram    [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [31:0] ref_rdata = '0;

  always_comb begin
    drv_en  = tb_rd | probe_en;
    drv_val = tb_rd ? sram[saddr[9:0]] : PROBE;
  end
  assign bus = drv_en ? drv_val : 16'hzzzz;
  always @(posedge clk) if (!sctrl[4]) sram[saddr[9:0]] <= bus;

  sram_burst_ctrl u_dut (
    .clk(clk), .rst(rst), .memReadEn(rd), .memWriteEn(wr), .address(addr),
    .writeData(wdata), .readData(rdata), .ready(rdy), .sramData(bus),
    .sramAddress(saddr), .sramCtrl(sctrl)
  );

  // 64-bit instance (read only)
  logic        rd64 = 1'b0, wr64 = 1'b0, tb_rd64 = 1'b0;
  logic [31:0] addr64 = '0;
  logic [63:0] wdata64 = '0, rdata64;
  logic        rdy64;
  wire  [15:0] bus64;
  logic [17:0] saddr64;
  logic [4:0]  sctrl64;
  logic [15:0] sram64 [0:15];
  logic [15:0] drv64;

  always_comb drv64 = sram64[saddr64[3:0]];
  assign bus64 = tb_rd64 ? drv64 : 16'hzzzz;

  sram_burst_ctrl #(.WORD_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .memReadEn(rd64), .memWriteEn(wr64), .address(addr64),
    .writeData(wdata64), .readData(rdata64), .ready(rdy64), .sramData(bus64),
    .sramAddress(saddr64), .sramCtrl(sctrl64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One access on the 32-bit port; expectations come from the spec's
  // address/beat arithmetic and the transaction-level reference memory.
  task automatic xact(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input bit scramble);
    int lo, we_lo, cyc, k, c;
    bit addr_ok, data_ok, we_ok;
    logic [17:0] hw;
    lo = 0; we_lo = 0; cyc = 0;
    addr_ok = 1; data_ok = 1; we_ok = 1;
    hw = 18'(((a - 32'd1024) >> 2) * 2);
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d; tb_rd = r && !w;
    #1;
    while (!rdy && cyc < 100) begin
      lo++;
      if (cyc > 0) begin
        k = (cyc - 1) / WAIT;
        c = (cyc - 1) % WAIT;
        if (saddr !== hw + 18'(k)) addr_ok = 0;
        if (!sctrl[4]) we_lo++;
        if (w) begin
          if (bus !== d[16*k +: 16]) data_ok = 0;
          if (sctrl[4] !== (c == WAIT - 1)) we_ok = 0;
        end
      end
      if (scramble && cyc == 1) begin addr = $urandom; wdata = $urandom; end
      if (scramble && cyc == 3) begin rd = 0; wr = 0; end
      @(negedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("timeout", 1, 0);
    if (w) begin
      ref_mem[hw[9:0]]      = d[15:0];
      ref_mem[hw[9:0] + 1]  = d[31:16];
    end else begin
      ref_rdata = {ref_mem[hw[9:0] + 1], ref_mem[hw[9:0]]};
    end
    chk("ready_low_cycles", lo, 1 + 2 * WAIT);
    chk("we_low_cycles", we_lo, w ? 2 * (WAIT - 1) : 0);
    chk("addr_seq", addr_ok, 1);
    chk("readData", rdata, ref_rdata);
    if (w) begin
      chk("bus_data", data_ok, 1);
      chk("we_pattern", we_ok, 1);
      chk("mem", {sram[hw[9:0] + 1], sram[hw[9:0]]}, {ref_mem[hw[9:0] + 1], ref_mem[hw[9:0]]});
    end
    rd = 0; wr = 0; tb_rd = 0;
    @(negedge clk); #1;
    chk("ready_after", rdy, 1);
  endtask

  initial begin
    int lo, cyc;
    bit ok_r, ok_w, ok_b, ok_c, ok_a;
    logic [31:0] a, d;
    bit w, r;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    for (int i = 0; i < 16; i++) sram64[i] = 16'($urandom);

    // reset state
    probe_en = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", rdy, 1);
    chk("rst_readData", rdata, 0);
    chk("rst_sramAddress", saddr, 0);
    chk("rst_ctrl", sctrl, 5'b10000);
    chk("rst_bus_hiz", bus, PROBE);
    chk("rst_readData64", rdata64, 0);
    @(negedge clk);
    rst = 1;
    probe_en = 0;

    // idle for 20 cycles
    probe_en = 1;
    ok_r = 1; ok_w = 1; ok_b = 1; ok_c = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rdy !== 1'b1) ok_r = 0;
      if (sctrl[4] !== 1'b1) ok_w = 0;
      if (bus !== PROBE) ok_b = 0;
      if (sctrl[3:0] !== 4'b0000) ok_c = 0;
    end
    chk("idle_ready", ok_r, 1);
    chk("idle_we_n", ok_w, 1);
    chk("idle_bus_hiz", ok_b, 1);
    chk("idle_ctrl_low", ok_c, 1);
    probe_en = 0;

    // directed: write then read back DEADBEEF at the base address
    xact(1, 0, 32'd1024, 32'hDEADBEEF, 0);
    xact(0, 1, 32'd1024, 32'h0, 0);
    chk("read_deadbeef", rdata, 32'hDEADBEEF);

    // both requests high: write only, readData untouched
    xact(1, 1, 32'd1040, 32'hCAFEF00D, 0);
    chk("both_keeps_rdata", rdata, 32'hDEADBEEF);
    xact(0, 1, 32'd1040, 32'h0, 0);

    // reset during beat 1 of a write to halfwords 4/5
    @(negedge clk);
    wr = 1; addr = 32'd1032; wdata = 32'h1234_5678;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_we_low", sctrl[4], 0);
    rst = 0; probe_en = 1;
    #1;
    chk("mid_rst_we_n", sctrl[4], 1);
    chk("mid_rst_bus_hiz", bus, PROBE);
    chk("mid_rst_ready", rdy, 1);
    chk("mid_rst_addr", saddr, 0);
    chk("mid_rst_readData", rdata, 0);
    wr = 0;
    ref_mem[4] = 16'h5678;
    ref_rdata = '0;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_ready", rdy, 1);
    chk("post_rst_bus_hiz", bus, PROBE);
    probe_en = 0;
    xact(0, 1, 32'd1032, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      a = 32'd1024 + 4 * $urandom_range(0, 200) + $urandom_range(0, 3);
      d = $urandom;
      xact(w, r, a, d, 1'($urandom));
    end

    // 64-bit instance: read at 1032 covers halfwords 4..7
    @(negedge clk);
    rd64 = 1; addr64 = 32'd1032; tb_rd64 = 1;
    #1;
    lo = 0; cyc = 0; ok_a = 1;
    while (!rdy64 && cyc < 100) begin
      lo++;
      if (cyc > 0 && saddr64 !== 18'(4 + (cyc - 1) / WAIT)) ok_a = 0;
      @(negedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("timeout64", 1, 0);
    chk("w64_ready_low_cycles", lo, 1 + 4 * WAIT);
    chk("w64_addr_seq", ok_a, 1);
    chk("w64_readData", rdata64, {sram64[7], sram64[6], sram64[5], sram64[4]});
    rd64 = 0; tb_rd64 = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
